alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Producer side of the ALU operation interface: decodes RV32I OP and OP-IMM instructions into the ALU's 3-bit opcode plus its two 32-bit operands.
- Buffers decoded operations in a small FIFO and presents them to the ALU under valid/ready.
- Sits between register-file read and the ALU in the execute path.
- Non-ALU or unsupported encodings are forwarded as flagged no-ops.

Parameters:
DEPTH, 2, number of buffer entries; power of two, minimum 2.
TAG_W, 32, width of the opaque tag carried alongside each op (PC).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; empties buffer
in_valid  input  1  instruction/operands valid
in_ready  output  1  buffer can accept
in_instr  input  32  raw instruction word
in_rs1  input  32  rs1 register value
in_rs2  input  32  rs2 register value
in_tag  input  TAG_W  passthrough tag
out_valid  output  1  decoded op valid
out_ready  input  1  ALU side accepts
out_opcode  output  3  ALU opcode
out_in_0  output  32  ALU operand 0
out_in_1  output  32  ALU operand 1
out_rd  output  5  destination register index
out_illegal  output  1  op is not a supported ALU instruction
out_tag  output  TAG_W  passthrough tag

Behaviour:
- One clock; reset is asynchronous and active-high. Reset empties the buffer. out_valid=0, in_ready=1 within reset. All out_* data read 0 while empty.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready; both may occur in one cycle.
- in_ready = (count < DEPTH). It is registered state only, with no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- Latency: an op pushed at edge N is visible on out_* after edge N if the buffer was empty. Otherwise FIFO order is preserved.
- Outputs come from the head entry. They are stable while out_valid&&!out_ready.
- flush: count and pointers reset at the next edge. Flush wins over a simultaneous push or pop; the pushed data is dropped.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Decode is combinational on the input side and registered into the entry.
- OP (0110011):
  - funct3 000: funct7 0000000 gives ADD; funct7 0100000 gives SUB.
  - 001 gives SLL; 100 gives XOR; 110 gives OR; 111 gives AND.
  - 101: funct7 0000000 gives SRL; funct7 0100000 gives SRA.
  - in_1 = in_rs2.
- OP-IMM (0010011):
  - ADDI, XORI, ORI, ANDI use in_1 = sign-extended instr[31:20].
  - SLLI/SRLI/SRAI use in_1 = zero-extended instr[24:20]. funct7 must be 0000000 (SLLI/SRLI) or 0100000 (SRAI).
- in_0 = in_rs1 and rd = instr[11:7] for all legal ops.
- Illegal: any other opcode, funct3 010/011 (SLT/SLTU), or any unlisted funct7. Result: out_illegal=1, opcode ADD, in_0=in_1=0, rd=0, tag still passed.
- Opcode encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7.

Optional Feature:
- ALU_ISSUE_PERF_EN defined adds two outputs:
  - perf_issued [31:0]: counts pops.
  - perf_illegal [31:0]: counts pops with out_illegal=1.
  - Both are cleared by reset, not by flush, and wrap at 2^32.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_defs holds:
  - the 3-bit ALU opcode constants;
  - RV32I opcode constants OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011;
  - funct7 constants F7_BASE=7'b0000000 and F7_ALT=7'b0100000.
- The ALU and this block both include it.
- One sub-module: alu_issue_decode, purely combinational: instr, rs1, rs2 -> opcode, in_0, in_1, rd, illegal.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=15, rs2=10 -> next cycle out_valid=1, opcode=0, in_0=15, in_1=10, rd=3, illegal=0.
- ADDI x1,x1,-5 (0xFFB08093), rs1=7 -> in_1=0xFFFFFFFB, opcode=0. Then SRAI x1,x1,3 (0x4030D093) -> opcode=7, in_1=3.
- SUB x3,x1,x2 (0x402081B3) -> opcode=1. SLT (0x0020A1B3) -> illegal=1, opcode=0, in_0=in_1=0, tag preserved.
- out_ready=0, push 3 ops back-to-back -> in_ready drops after 2nd push and the 3rd is held. Raise out_ready -> ops emerge in order, one per cycle, with no loss.
- Full buffer, then flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle op absent.
- Assert reset asynchronously mid-stream with 2 entries queued -> out_valid=0 immediately without a clock edge. With ALU_ISSUE_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: the 3-bit ALU opcode, the RV32I major opcodes and the funct7 values
// used by both the ALU and its issue stage.
package alu_defs;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSra = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // One decoded buffer entry; the tag is stored alongside because its width is a parameter.
  typedef struct packed {
    alu_op_e     opcode;
    logic [31:0] in_0;
    logic [31:0] in_1;
    logic [4:0]  rd;
    logic        illegal;
  } decoded_op_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP / OP-IMM decoder producing ALU opcode, operands and destination.
// Anything outside the supported subset comes out as an illegal, zeroed ADD.
module alu_issue_decode
  import alu_defs::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output alu_op_e     opcode_o,
  output logic [31:0] in_0_o,
  output logic [31:0] in_1_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        unused_rs1_field;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt = {27'd0, instr_i[24:20]};

  // Register values arrive already read, so the rs1 field itself is not needed here.
  assign unused_rs1_field = ^instr_i[19:15];

  alu_op_e     op_sel;
  logic        legal;
  logic [31:0] opnd_1;

  always_comb begin
    op_sel = AluAdd;
    legal  = 1'b0;
    opnd_1 = rs2_i;
    if (opc == OPC_OP) begin
      opnd_1 = rs2_i;
      case (f3)
        F3_ADD: begin
          if (f7 == F7_BASE) begin
            op_sel = AluAdd;
            legal  = 1'b1;
          end else if (f7 == F7_ALT) begin
            op_sel = AluSub;
            legal  = 1'b1;
          end
        end
        F3_SLL: begin
          op_sel = AluSll;
          legal  = (f7 == F7_BASE);
        end
        F3_XOR: begin
          op_sel = AluXor;
          legal  = (f7 == F7_BASE);
        end
        F3_OR: begin
          op_sel = AluOr;
          legal  = (f7 == F7_BASE);
        end
        F3_AND: begin
          op_sel = AluAnd;
          legal  = (f7 == F7_BASE);
        end
        F3_SR: begin
          if (f7 == F7_BASE) begin
            op_sel = AluSrl;
            legal  = 1'b1;
          end else if (f7 == F7_ALT) begin
            op_sel = AluSra;
            legal  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (opc == OPC_OP_IMM) begin
      opnd_1 = imm_i;
      case (f3)
        F3_ADD: begin
          op_sel = AluAdd;
          legal  = 1'b1;
        end
        F3_XOR: begin
          op_sel = AluXor;
          legal  = 1'b1;
        end
        F3_OR: begin
          op_sel = AluOr;
          legal  = 1'b1;
        end
        F3_AND: begin
          op_sel = AluAnd;
          legal  = 1'b1;
        end
        F3_SLL: begin
          opnd_1 = shamt;
          op_sel = AluSll;
          legal  = (f7 == F7_BASE);
        end
        F3_SR: begin
          opnd_1 = shamt;
          if (f7 == F7_BASE) begin
            op_sel = AluSrl;
            legal  = 1'b1;
          end else if (f7 == F7_ALT) begin
            op_sel = AluSra;
            legal  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    opcode_o  = AluAdd;
    in_0_o    = 32'd0;
    in_1_o    = 32'd0;
    rd_o      = 5'd0;
    illegal_o = 1'b1;
    if (legal) begin
      opcode_o  = op_sel;
      in_0_o    = rs1_i;
      in_1_o    = opnd_1;
      rd_o      = instr_i[11:7];
      illegal_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes OP/OP-IMM instructions into a DEPTH-entry FIFO feeding the ALU.
// Define ALU_ISSUE_PERF_EN to add the perf_issued / perf_illegal pop counters.
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_opcode,
  output logic [31:0]      out_in_0,
  output logic [31:0]      out_in_1,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_illegal
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  decoded_op_t dec;
  alu_op_e     dec_opcode;

  alu_issue_decode u_decode (
    .instr_i   (in_instr),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .opcode_o  (dec_opcode),
    .in_0_o    (dec.in_0),
    .in_1_o    (dec.in_1),
    .rd_o      (dec.rd),
    .illegal_o (dec.illegal)
  );

  assign dec.opcode = dec_opcode;

  decoded_op_t      mem_q [DEPTH];
  decoded_op_t      mem_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  logic push;
  logic pop;

  // in_ready depends only on the stored count, so a full buffer never accepts even on a pop.
  assign in_ready  = (count_q < Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        tag_d[wr_ptr_q] = in_tag;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      tag_q    <= tag_d;
    end
  end

  decoded_op_t head;

  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_opcode  = 3'd0;
    out_in_0    = 32'd0;
    out_in_1    = 32'd0;
    out_rd      = 5'd0;
    out_illegal = 1'b0;
    out_tag     = '0;
    if (out_valid) begin
      out_opcode  = head.opcode;
      out_in_0    = head.in_0;
      out_in_1    = head.in_1;
      out_rd      = head.rd;
      out_illegal = head.illegal;
      out_tag     = tag_q[rd_ptr_q];
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_illegal_q, perf_illegal_d;

  always_comb begin
    perf_issued_d  = perf_issued_q;
    perf_illegal_d = perf_illegal_q;
    if (pop) begin
      perf_issued_d = perf_issued_q + 32'd1;
      if (out_illegal) begin
        perf_illegal_d = perf_illegal_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued_q  <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule
